pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed-field ID/EX register: a generic inter-stage pipeline register with valid/ready flow control.
- Uses a 2-entry skid buffer, synchronous flush, and bubble insertion with zeroed control fields.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). A stalled downstream stage can back-pressure upstream without combinational ready paths.
- Includes a saturating bubble counter for performance monitoring.

Parameters:
- DBITS, 96, width of data payload (register values, immediate, register names); never zeroed on bubble.
- CBITS, 16, width of control payload (regwrite, memread, memwrite, aluop, ...); forced to 0 whenever output is invalid.
- BCNT_W, 16, width of bubble counter.

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous flush; drops all held and incoming entries
- i_valid  in  1  upstream entry valid
- o_ready  out  1  stage can accept an entry; driven from state register only
- i_data  in  DBITS  upstream data payload
- i_ctrl  in  CBITS  upstream control payload
- o_valid  out  1  output entry valid
- i_ready  in  1  downstream accepts the output entry
- o_data  out  DBITS  output data payload
- o_ctrl  out  CBITS  output control payload; 0 when o_valid=0
- o_occupancy  out  2  entries held: 0, 1 or 2
- i_clr_cnt  in  1  synchronous clear of bubble counter
- o_bubbles  out  BCNT_W  saturating count of cycles with o_valid=0

Behaviour:
- Reset (i_rst_n=0, asynchronous): state EMPTY; main and skid data/ctrl registers 0; o_valid=0; o_ready=1; o_data=0; o_ctrl=0; o_occupancy=0; o_bubbles=0. Reset may assert mid-transfer; held entries are discarded with no partial output.
- Handshakes:
  - In-accept = i_valid & o_ready.
  - Out-accept = o_valid & i_ready.
  - Both may occur in the same cycle.
- States: EMPTY (occupancy 0), FULL (main valid, occupancy 1), SKID (main and skid valid, occupancy 2).
- o_valid = (state != EMPTY). o_ready = (state != SKID). Both are pure functions of the state register; no combinational path from i_ready or i_valid.
- Transitions, evaluated when i_flush=0:
  - EMPTY: in-accept -> FULL, main <= input.
  - FULL: in-accept & out-accept -> FULL, main <= input.
  - FULL: in-accept & !out-accept -> SKID, skid <= input, main held.
  - FULL: !in-accept & out-accept -> EMPTY.
  - FULL: otherwise hold.
  - SKID: out-accept -> FULL, main <= skid. Input is not accepted since o_ready=0.
  - SKID: otherwise hold.
- Latency: 1 cycle from in-accept to o_valid when empty. Throughput is 1 entry/cycle while i_ready=1.
- Ordering: strict FIFO; the skid entry always follows the main entry.
- Flush (i_flush=1): highest priority after reset. Next state EMPTY; any same-cycle in-accept is discarded. Main and skid ctrl registers are cleared to 0; data registers are held. o_valid is low in the following cycle. A same-cycle out-accept still counts as delivered downstream.
- Bubble rule: o_ctrl = main_ctrl when o_valid=1, else 0. o_data = main data register at all times.
- Payload stability: while o_valid=1 and i_ready=0, o_data and o_ctrl remain constant.
- Bubble counter:
  - Increments by 1 each cycle o_valid=0.
  - Saturates at 2^BCNT_W-1; no wrap.
  - i_clr_cnt=1 sets it to 0 on the next edge. Clear has priority over increment.
  - Flush does not clear the counter.
- o_occupancy encoding: EMPTY=0, FULL=1, SKID=2. The value 3 never appears.

Test Plan:
- Reset then stream: after release, i_valid=1 and i_ready=1 for 4 cycles with i_data=1,2,3,4 -> o_valid from cycle 1, o_data=1,2,3,4 on consecutive cycles, o_ready constant 1, o_occupancy=1.
- Back-pressure: in FULL with o_data=5, hold i_ready=0 and send 6, then 7 -> 6 accepted into skid (occupancy 2), o_ready=0 next cycle, 7 held upstream. Raise i_ready -> outputs 5,6,7 in order; o_data stays 5 throughout the stall.
- Bubble control: i_ctrl=16'hFFFF sent once, then i_valid=0 -> o_ctrl=16'hFFFF for 1 cycle, then 0. o_bubbles increments each empty cycle.
- Flush in SKID with i_valid=1 -> next cycle o_valid=0, o_ctrl=0, o_occupancy=0, o_ready=1. Neither held entry nor incoming entry appears later.
- Async reset mid-stall: assert i_rst_n=0 between clock edges in SKID -> o_valid=0, o_ready=1, o_occupancy=0, o_bubbles=0 immediately, without waiting for a clock edge.
- Counter saturation (BCNT_W=4): 20 idle cycles -> o_bubbles=15. Pulse i_clr_cnt while idle -> 0 on next edge, then 1 on the following edge.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready inter-stage register with a 2-entry skid buffer,
// synchronous flush, bubble ctrl zeroing and a saturating bubble counter.
module pipe_stage_elastic #(
    parameter int DBITS  = 96,
    parameter int CBITS  = 16,
    parameter int BCNT_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DBITS-1:0]  i_data,
    input  logic [CBITS-1:0]  i_ctrl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DBITS-1:0]  o_data,
    output logic [CBITS-1:0]  o_ctrl,
    output logic [1:0]        o_occupancy,
    input  logic              i_clr_cnt,
    output logic [BCNT_W-1:0] o_bubbles
);
    localparam logic [1:0] EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2;
    logic [1:0]        state, state_nxt;
    logic [DBITS-1:0]  main_data, skid_data;
    logic [CBITS-1:0]  main_ctrl, skid_ctrl;
    logic [BCNT_W-1:0] bcnt;
    logic              in_acc, out_acc, load_main, load_skid;
    // handshake outputs come straight from the state register
    assign o_valid     = state != EMPTY;
    assign o_ready     = state != SKID;
    assign o_occupancy = state;
    assign o_data      = main_data;
    assign o_ctrl      = o_valid ? main_ctrl : '0;
    assign o_bubbles   = bcnt;
    always_comb begin
        in_acc    = i_valid & o_ready;
        out_acc   = o_valid & i_ready;
        load_main = (state == EMPTY & in_acc) | (state == FULL & in_acc & out_acc) | (state == SKID & out_acc);
        load_skid = state == FULL & in_acc & ~out_acc;
        state_nxt = i_flush ? EMPTY :
                    state == EMPTY ? (in_acc ? FULL : EMPTY) :
                    state == FULL ? (load_skid ? SKID : (out_acc & ~in_acc) ? EMPTY : FULL) :
                    (out_acc ? FULL : SKID);
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
            bcnt      <= '0;
        end else begin
            state <= state_nxt;
            if (i_flush) begin
                main_ctrl <= '0;
                skid_ctrl <= '0;
            end else begin
                if (load_main) begin
                    main_data <= state == SKID ? skid_data : i_data;
                    main_ctrl <= state == SKID ? skid_ctrl : i_ctrl;
                end
                if (load_skid) begin
                    skid_data <= i_data;
                    skid_ctrl <= i_ctrl;
                end
            end
            bcnt <= i_clr_cnt ? '0 : (!o_valid && bcnt != '1) ? bcnt + 1'b1 : bcnt;
        end
    end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: directed + random stimulus against an abstract 2-deep FIFO model,
// with a scoreboard queue popped by an independent output monitor.
module tb_pipe_stage_elastic;
    logic         i_clk = 0, i_rst_n = 0, i_flush = 0, i_valid = 0, i_ready = 0, i_clr_cnt = 0;
    logic [95:0]  i_data = '0;
    logic [15:0]  i_ctrl = '0;
    logic         o_ready, o_valid;
    logic [95:0]  o_data;
    logic [15:0]  o_ctrl;
    logic [1:0]   o_occupancy;
    logic [3:0]   o_bubbles;
    logic [111:0] exp_q[$];
    int           cnt = 0, bub = 0, checks = 0, errors = 0;
    bit           mon_en = 0;

    pipe_stage_elastic #(.DBITS(96), .CBITS(16), .BCNT_W(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_ctrl(i_ctrl), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_ctrl(o_ctrl), .o_occupancy(o_occupancy), .i_clr_cnt(i_clr_cnt), .o_bubbles(o_bubbles)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // monitor: FIFO status against the model, payload against the scoreboard on each delivery
    always @(negedge i_clk) if (mon_en) begin
        logic [111:0] e;
        chk("valid", o_valid, cnt > 0);
        chk("ready", o_ready, cnt < 2);
        chk("occupancy", o_occupancy, cnt);
        chk("bubbles", o_bubbles, bub);
        if (!o_valid) chk("ctrl_bubble", o_ctrl, 0);
        if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output at %0t: got data %0h, expected nothing", $time, o_data);
            end else begin
                e = exp_q.pop_front();
                chk("data", o_data, e[111:16]);
                chk("ctrl", o_ctrl, e[15:0]);
            end
        end
    end

    // drive one cycle of inputs, then advance the abstract model past the edge
    task automatic step(input bit v, input logic [95:0] d, input logic [15:0] c,
                        input bit r, input bit f, input bit clr);
        bit oa, ia;
        i_valid = v; i_data = d; i_ctrl = c; i_ready = r; i_flush = f; i_clr_cnt = clr;
        @(posedge i_clk); #1;
        oa = cnt > 0 && r;
        ia = v && cnt < 2;
        if (clr) bub = 0;
        else if (cnt == 0 && bub < 15) bub++;
        if (f) begin
            exp_q.delete();
            cnt = 0;
        end else begin
            if (oa) cnt--;
            if (ia) begin
                cnt++;
                exp_q.push_back({d, c});
            end
        end
    endtask

    task automatic idle(input bit r);
        step(0, '0, '0, r, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_occ", o_occupancy, 0);
        chk("rst_data", o_data, 0);
        chk("rst_bub", o_bubbles, 0);
        i_rst_n = 1;
        mon_en = 1;
        for (int k = 1; k <= 4; k++) step(1, 96'(k), 16'(k), 1, 0, 0);
        idle(1);
        // back-pressure into the skid slot, then drain in order
        step(1, 96'd5, 16'h5, 1, 0, 0);
        step(1, 96'd6, 16'h6, 0, 0, 0);
        step(1, 96'd7, 16'h7, 0, 0, 0);
        step(1, 96'd7, 16'h7, 0, 0, 0);
        step(0, '0, '0, 1, 0, 0);
        idle(1);
        idle(1);
        idle(1);
        step(1, 96'd8, 16'hFFFF, 1, 0, 0);
        repeat (3) idle(1);
        // flush while holding two entries with a live incoming entry
        step(1, 96'd9, 16'h9, 0, 0, 0);
        step(1, 96'd10, 16'hA, 0, 0, 0);
        step(1, 96'd11, 16'hB, 0, 1, 0);
        repeat (2) idle(1);
        // saturation and clear
        repeat (20) idle(0);
        step(0, '0, '0, 0, 0, 1);
        repeat (2) idle(0);
        // async reset in the middle of a stall
        step(1, 96'd12, 16'hC, 0, 0, 0);
        step(1, 96'd13, 16'hD, 0, 0, 0);
        #2;
        mon_en = 0;
        i_rst_n = 0;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_ready", o_ready, 1);
        chk("arst_occ", o_occupancy, 0);
        chk("arst_bub", o_bubbles, 0);
        chk("arst_ctrl", o_ctrl, 0);
        chk("arst_data", o_data, 0);
        exp_q.delete();
        cnt = 0;
        bub = 0;
        i_valid = 0; i_ready = 0;
        @(posedge i_clk); #1;
        i_rst_n = 1;
        mon_en = 1;
        for (int k = 0; k < 600; k++)
            step($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom}, 16'($urandom),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0, $urandom_range(0, 49) == 0);
        repeat (3) idle(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
